// File: rtl/icache_refill_server.sv
// ICache miss responder: fetches one aligned line from a synchronous ROM, one word per cycle, pipelined.
// Latency: resp_valid pulses WORDS_PER_LINE+READ_LAT+1 cycles after acceptance; req_ready is low while busy.
module icache_refill_server #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ROM_ADDR_W     = 14,
  parameter int READ_LAT       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [31:0]                 req_addr,
  output logic                        req_ready,
  input  logic                        flush,
  output logic                        resp_valid,
  output logic [31:0]                 resp_addr,
  output logic [32*WORDS_PER_LINE-1:0] resp_line,
  output logic                        rom_en,
  output logic [ROM_ADDR_W-1:0]       rom_addr,
  input  logic [31:0]                 rom_rdata
);

  localparam int LW  = $clog2(WORDS_PER_LINE);
  localparam int CW  = LW + 1;
  localparam int OFF = LW + 2;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF) - 32'd1);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]                 cap_cnt_q, cap_cnt_d;
  logic                          drop_q, drop_d;
  logic [READ_LAT-1:0]           rd_pipe_q, rd_pipe_d;
  logic                          rom_en_q, rom_en_d;
  logic [ROM_ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic                          resp_vld_q, resp_vld_d;
  logic [31:0]                   resp_addr_q, resp_addr_d;
  logic [32*WORDS_PER_LINE-1:0]  resp_line_q, resp_line_d;

  always_comb begin
    state_d     = state_q;
    iss_cnt_d   = iss_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    drop_d      = drop_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    resp_vld_d  = 1'b0;
    resp_addr_d = resp_addr_q;
    resp_line_d = resp_line_q;
    // rd_pipe tracks which ROM reads are in flight, so data is captured exactly READ_LAT after issue
    rd_pipe_d[0] = rom_en_q;
    for (int k = 1; k < READ_LAT; k++) begin
      rd_pipe_d[k] = rd_pipe_q[k-1];
    end

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          state_d     = FILL;
          resp_addr_d = req_addr & LINE_MASK;
          rom_en_d    = 1'b1;
          rom_addr_d  = resp_addr_d[ROM_ADDR_W+1:2];
          iss_cnt_d   = CW'(1);
          cap_cnt_d   = '0;
          drop_d      = 1'b0;
        end
      end
      FILL: begin
        if (iss_cnt_q < CW'(WORDS_PER_LINE)) begin
          rom_en_d   = 1'b1;
          rom_addr_d = rom_addr_q + ROM_ADDR_W'(1);
          iss_cnt_d  = iss_cnt_q + CW'(1);
        end
        if (flush) begin
          drop_d = 1'b1;
        end
        // A flushed refill still drains every issued read before returning to IDLE
        if (rd_pipe_q[READ_LAT-1]) begin
          resp_line_d[32*cap_cnt_q[LW-1:0] +: 32] = rom_rdata;
          cap_cnt_d = cap_cnt_q + CW'(1);
          if (cap_cnt_q == CW'(WORDS_PER_LINE-1)) begin
            state_d    = drop_d ? IDLE : RESP;
            resp_vld_d = !drop_d;
            drop_d     = 1'b0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      iss_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      drop_q      <= 1'b0;
      rd_pipe_q   <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      resp_vld_q  <= 1'b0;
      resp_addr_q <= '0;
      resp_line_q <= '0;
    end else begin
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      drop_q      <= drop_d;
      rd_pipe_q   <= rd_pipe_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      resp_vld_q  <= resp_vld_d;
      resp_addr_q <= resp_addr_d;
      resp_line_q <= resp_line_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_vld_q && !flush;
  assign resp_addr  = resp_addr_q;
  assign resp_line  = resp_line_q;
  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_icache_refill_server.sv
// Bench for icache_refill_server: READ_LAT=1 and READ_LAT=3 instances share one stimulus,
// each checked every cycle against a transaction-level timing model.
module tb_icache_refill_server;
  localparam int W  = 4;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst, req_valid, flush;
  logic [31:0] req_addr;

  logic rr[2], rv[2], re[2];
  logic [31:0] ra[2], rd[2];
  logic [127:0] rl[2];
  logic [AW-1:0] rad[2];

  always #5 clk = ~clk;

  icache_refill_server #(.WORDS_PER_LINE(W), .ROM_ADDR_W(AW), .READ_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr[0]),
    .flush(flush), .resp_valid(rv[0]), .resp_addr(ra[0]), .resp_line(rl[0]),
    .rom_en(re[0]), .rom_addr(rad[0]), .rom_rdata(rd[0]));

  icache_refill_server #(.WORDS_PER_LINE(W), .ROM_ADDR_W(AW), .READ_LAT(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(rr[1]),
    .flush(flush), .resp_valid(rv[1]), .resp_addr(ra[1]), .resp_line(rl[1]),
    .rom_en(re[1]), .rom_addr(rad[1]), .rom_rdata(rd[1]));

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return {18'b0, a} * 32'h11;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    logic [31:0] wa;
    l = '0;
    for (int i = 0; i < W; i++) begin
      wa = (base >> 2) + 32'(i);
      l[32*i +: 32] = rom_word(wa[AW-1:0]);
    end
    return l;
  endfunction

  // ROM models; unread slots return a poison word so mistimed captures show up
  logic [31:0] st0 [1];
  logic [31:0] st1 [3];
  always @(posedge clk) begin
    st0[0] <= re[0] ? rom_word(rad[0]) : 32'hDEAD_BEEF;
    st1[0] <= re[1] ? rom_word(rad[1]) : 32'hDEAD_BEEF;
    st1[1] <= st1[0];
    st1[2] <= st1[1];
  end
  assign rd[0] = st0[0];
  assign rd[1] = st1[2];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Model: one refill per instance, described by acceptance cycle, base and drop status
  int lat[2] = '{1, 3};
  int t_acc[2];
  bit busy[2], dropped[2], known[2];
  logic [31:0] m_base[2], m_ra[2];
  logic [127:0] m_line[2];

  function automatic int idle_from(input int d);
    return t_acc[d] + W + lat[d] + (dropped[d] ? 1 : 2);
  endfunction

  function automatic bit in_refill(input int d, input int c);
    return busy[d] && c >= t_acc[d] + 1 && c < idle_from(d);
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      busy[d] = 0; dropped[d] = 0; known[d] = 0; t_acc[d] = 0;
      m_base[d] = 0; m_ra[d] = 0; m_line[d] = 0;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy[d] = 0; dropped[d] = 0; m_ra[d] = 0; m_line[d] = 0; known[d] = 1;
      end else begin
        if (busy[d] && cyc >= t_acc[d] + 1 && cyc <= t_acc[d] + W + lat[d] && flush)
          dropped[d] = 1;
        if (busy[d] && cyc == t_acc[d] + W + lat[d]) begin
          known[d] = 1;
          m_line[d] = line_of(m_base[d]);
        end
        if (!in_refill(d, cyc) && req_valid && !flush) begin
          busy[d] = 1; t_acc[d] = cyc; dropped[d] = 0; known[d] = 0;
          m_base[d] = req_addr & 32'hFFFF_FFF0;
          m_ra[d] = m_base[d];
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        bit e_en, e_rv;
        logic [31:0] wa;
        e_en = busy[d] && cyc >= t_acc[d] + 1 && cyc <= t_acc[d] + W;
        e_rv = busy[d] && cyc == t_acc[d] + W + lat[d] + 1 && !dropped[d] && !flush;
        chk($sformatf("req_ready[%0d]", d), 128'(rr[d]), 128'(!in_refill(d, cyc)));
        chk($sformatf("rom_en[%0d]", d), 128'(re[d]), 128'(e_en));
        if (e_en) begin
          wa = (m_base[d] >> 2) + 32'(cyc - t_acc[d] - 1);
          chk($sformatf("rom_addr[%0d]", d), 128'(rad[d]), 128'(wa[AW-1:0]));
        end
        chk($sformatf("resp_valid[%0d]", d), 128'(rv[d]), 128'(e_rv));
        chk($sformatf("resp_addr[%0d]", d), 128'(ra[d]), 128'(m_ra[d]));
        if (known[d]) chk($sformatf("resp_line[%0d]", d), rl[d], m_line[d]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic at_cycle(input int n);
    goto(n);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] a, output int t);
    req_valid = 1'b1;
    req_addr = a;
    step();
    t = cyc - 1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rr[0] && rr[1]) ok = 1;
      else step();
    end
    if (!ok) chk("wait_idle_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    int t;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; req_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_ready", 128'(rr[0]), 128'(1));
    chk("lit_reset_line", rl[0], 128'(0));
    chk("lit_reset_rom_en", 128'(re[0]), 128'(0));

    // Basic refill
    wait_idle();
    send(32'h0000_0048, t);
    at_cycle(t + 1);
    chk("lit_first_addr", 128'(re[0] ? rad[0] : 14'h3FFF), 128'(14'h10));
    at_cycle(t + 4);
    chk("lit_last_addr", 128'(rad[0]), 128'(14'h13));
    at_cycle(t + 6);
    chk("lit_resp_valid0", 128'(rv[0]), 128'(1));
    chk("lit_resp_addr0", 128'(ra[0]), 128'(32'h40));
    chk("lit_resp_line0", rl[0], 128'h00000143_00000132_00000121_00000110);
    chk("lit_resp_valid1_early", 128'(rv[1]), 128'(0));
    at_cycle(t + 8);
    chk("lit_resp_valid1", 128'(rv[1]), 128'(1));
    chk("lit_resp_line1", rl[1], 128'h00000143_00000132_00000121_00000110);

    // Flush mid-refill
    wait_idle();
    send(32'h0000_0048, t);
    goto(t + 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("lit_flush_issue4", 128'(re[0]), 128'(1));
    at_cycle(t + 6);
    chk("lit_flush_ready", 128'(rr[0]), 128'(1));
    chk("lit_flush_no_resp", 128'(rv[0]), 128'(0));
    wait_idle();
    send(32'h0000_0200, t);
    wait_idle();

    // Back-to-back held requests
    req_valid = 1'b1; req_addr = 32'h0;
    step();
    t = cyc - 1;
    req_addr = 32'h10;
    at_cycle(t + 6);
    chk("lit_b2b_first", 128'(rv[0]), 128'(1));
    at_cycle(t + 7);
    chk("lit_b2b_ready", 128'(rr[0]), 128'(1));
    goto(t + 10);
    req_valid = 1'b0;
    at_cycle(t + 13);
    chk("lit_b2b_second", 128'(rv[0]), 128'(1));
    chk("lit_b2b_line", rl[0], 128'h00000077_00000066_00000055_00000044);

    // ROM top wrap
    wait_idle();
    send(32'h0000_FFF8, t);
    at_cycle(t + 1);
    chk("lit_top_first", 128'(rad[0]), 128'(14'h3FFC));
    at_cycle(t + 4);
    chk("lit_top_last", 128'(rad[0]), 128'(14'h3FFF));
    wait_idle();
    send(32'h0001_0000, t);
    at_cycle(t + 1);
    chk("lit_wrap_zero", 128'(rad[0]), 128'(0));
    wait_idle();

    // Reset mid-refill
    send(32'h0000_0048, t);
    goto(t + 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_resp_valid", 128'(rv[0]), 128'(0));
    chk("lit_rst_rom_en", 128'(re[0]), 128'(0));
    chk("lit_rst_rom_addr", 128'(rad[0]), 128'(0));
    chk("lit_rst_resp_addr", 128'(ra[0]), 128'(0));
    chk("lit_rst_ready", 128'(rr[0]), 128'(1));
    wait_idle();
    send(32'h0000_0088, t);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 19) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr = $urandom;
      step();
    end
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
    wait_idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
